// File: rtl/packer_pkg.sv
// Shared widths for the packer_tx / matching receiver pair.
// Holds the default word widths, the accumulator width and the fill
// counter width, plus the helper used to size the fill counter.
package packer_pkg;

  localparam int IN_W   = 10;
  localparam int OUT_W  = 21;
  // Worst case: OUT_W-1 bits waiting plus one fresh IN_W word.
  localparam int ACC_W  = IN_W + OUT_W - 1;
  localparam int FILL_W = $clog2(ACC_W + 1);

  // Bits needed to count 0..acc_w inclusive.
  function automatic int fill_bits(input int acc_w);
    return $clog2(acc_w + 1);
  endfunction

endpackage

// File: rtl/packer_tx.sv
// Purpose: packs IN_W-bit words LSB-first into a continuous stream of OUT_W-bit bus words.
// Latency: the word that completes OUT_W bits shows up on out_data one cycle after its accept.
// Backpressure: in_ready drops when a full word is waiting on !out_ready, or while a burst flush is pending.
//
// Ports:
//   clk, rst              single clock, asynchronous active-low reset
//   in_data/in_valid/     input word stream; in_last marks the final word
//   in_last/in_ready      of a burst and is qualified by in_valid
//   out_data/out_valid/   packed bus words; out_last marks the final,
//   out_last/out_ready    zero-padded word of a burst
module packer_tx #(
  parameter int IN_W  = packer_pkg::IN_W,
  parameter int OUT_W = packer_pkg::OUT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  output logic             out_last,
  input  logic             out_ready
);
  import packer_pkg::*;

  localparam int ACC_BITS  = IN_W + OUT_W - 1;
  localparam int FILL_BITS = fill_bits(ACC_BITS);

  localparam logic [FILL_BITS-1:0] OUT_CNT = FILL_BITS'(OUT_W);
  localparam logic [FILL_BITS-1:0] IN_CNT  = FILL_BITS'(IN_W);
  localparam logic [OUT_W-1:0]     ONES    = '1;

  logic [ACC_BITS-1:0]  acc;
  logic [ACC_BITS-1:0]  acc_nxt;
  logic [FILL_BITS-1:0] fill;
  logic [FILL_BITS-1:0] fill_nxt;
  logic                 flush_pend;
  logic                 flush_nxt;

  logic                 accept;
  logic                 xfer;
  logic                 flush_xfer;
  logic [FILL_BITS-1:0] ins_pos;
  logic [ACC_BITS-1:0]  in_ext;

  // ---------------------------------------------------------------------------
  // Outputs: all derived from registered state only.
  // ---------------------------------------------------------------------------
  assign out_valid = (fill >= OUT_CNT) || (flush_pend && (fill != '0));
  assign out_last  = flush_pend && (fill <= OUT_CNT);
  // Bits at or above fill are forced to zero so a flushed partial word is
  // padded even if the accumulator ever held stale upper bits.
  assign out_data  = acc[OUT_W-1:0] & ~(ONES << fill);
  assign in_ready  = !flush_pend && ((fill < OUT_CNT) || out_ready);

  // ---------------------------------------------------------------------------
  // Handshakes
  // ---------------------------------------------------------------------------
  assign accept     = in_valid && in_ready;
  assign xfer       = out_valid && out_ready;
  assign flush_xfer = xfer && out_last;
  assign in_ext     = ACC_BITS'(in_data);

  // Insert position of the new word. When a full word leaves in the same
  // cycle the residue has already moved down by OUT_W, so the new word lands
  // at fill-OUT_W. An accept never coincides with a flush transfer because
  // in_ready is low while flush_pend is set, so fill >= OUT_W whenever both
  // accept and xfer are true.
  assign ins_pos = xfer ? (fill - OUT_CNT) : fill;

  // ---------------------------------------------------------------------------
  // Next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    acc_nxt   = acc;
    fill_nxt  = fill;
    flush_nxt = flush_pend;

    if (xfer) begin
      acc_nxt  = acc >> OUT_W;
      fill_nxt = fill - OUT_CNT;
    end

    // The padded (or exactly full) final word of a burst empties everything.
    if (flush_xfer) begin
      acc_nxt   = '0;
      fill_nxt  = '0;
      flush_nxt = 1'b0;
    end

    if (accept) begin
      acc_nxt  = acc_nxt | (in_ext << ins_pos);
      fill_nxt = fill_nxt + IN_CNT;
      if (in_last) begin
        flush_nxt = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc        <= '0;
      fill       <= '0;
      flush_pend <= 1'b0;
    end else begin
      acc        <= acc_nxt;
      fill       <= fill_nxt;
      flush_pend <= flush_nxt;
    end
  end

endmodule

// File: tb/tb_packer_tx.sv
// Bench for packer_tx: constant vector table, directed multi-cycle sequences
// and a random valid/ready run checked against a bit-queue reference model.
module tb_packer_tx;

  localparam int IW = packer_pkg::IN_W;
  localparam int OW = packer_pkg::OUT_W;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [IW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic          in_ready;
  logic [OW-1:0] out_data;
  logic          out_valid;
  logic          out_last;
  logic          out_ready = 1'b0;

  always #5 clk = ~clk;

  packer_tx #(.IN_W(IW), .OUT_W(OW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_last (out_last),
    .out_ready(out_ready)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [OW-1:0] d;
    logic          l;
  } word_t;

  // Reference model: a plain bit stream cut into OW-bit words.
  bit    bits[$];
  word_t exp_q[$];
  word_t got_q[$];
  int    pend_bits;   // bits accepted but not yet carried out

  logic          prev_stall;
  logic [OW-1:0] prev_d;
  logic          prev_l;
  logic          s_in_ready, s_out_valid, s_out_last, s_acc, s_xfer;
  logic [OW-1:0] s_out_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_model();
    bits.delete();
    exp_q.delete();
    got_q.delete();
    pend_bits  = 0;
    prev_stall = 1'b0;
  endtask

  task automatic model_push(input logic [IW-1:0] d, input logic l);
    word_t w;
    int    n;
    for (int i = 0; i < IW; i++) bits.push_back(d[i]);
    while (bits.size() >= OW) begin
      w.d = '0;
      for (int j = 0; j < OW; j++) w.d[j] = bits.pop_front();
      w.l = 1'b0;
      exp_q.push_back(w);
    end
    if (l) begin
      if (bits.size() > 0) begin
        w.d = '0;
        n   = bits.size();
        for (int j = 0; j < n; j++) w.d[j] = bits.pop_front();
        w.l = 1'b1;
        exp_q.push_back(w);
      end else begin
        w   = exp_q.pop_back();
        w.l = 1'b1;
        exp_q.push_back(w);
      end
    end
  endtask

  // One clock: drive on the falling edge, sample 1ns later, account for the
  // handshakes that the next rising edge will commit.
  task automatic cyc(input logic iv, input logic [IW-1:0] id, input logic il, input logic ordy);
    word_t w;
    word_t e;
    @(negedge clk);
    in_valid  = iv;
    in_data   = id;
    in_last   = il;
    out_ready = ordy;
    #1;
    s_in_ready  = in_ready;
    s_out_valid = out_valid;
    s_out_last  = out_last;
    s_out_data  = out_data;
    if (prev_stall) begin
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_data", 32'(out_data), 32'(prev_d));
      chk("hold_last", 32'(out_last), 32'(prev_l));
    end
    s_xfer = out_valid && ordy;
    s_acc  = iv && in_ready;
    if (s_xfer) begin
      w.d = out_data;
      w.l = out_last;
      got_q.push_back(w);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_extra: got %0h expected no word", out_data);
      end else begin
        e = exp_q.pop_front();
        chk("sb_data", 32'(out_data), 32'(e.d));
        chk("sb_last", 32'(out_last), 32'(e.l));
      end
      pend_bits = out_last ? 0 : pend_bits - OW;
    end
    if (s_acc) begin
      model_push(id, il);
      pend_bits += IW;
    end
    prev_stall = out_valid && !ordy;
    prev_d     = out_data;
    prev_l     = out_last;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    clear_model();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  typedef struct {
    int            n_in;
    logic [IW-1:0] w0, w1, w2;
    logic          lst;
    int            n_out;
    logic [OW-1:0] d0, d1;
    logic          l0, l1;
  } vec_t;

  vec_t tv[6];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected test end");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [IW-1:0] wv[3];
    logic [OW-1:0] dv[2];
    logic          lv[2];
    int            nx, drops, sent, k;
    logic          exp_rdy, have, pl, ordy;
    logic [IW-1:0] pd;

    tv[0] = '{3, 10'h001, 10'h002, 10'h003, 1'b0, 1, 21'h100801, 21'h000000, 1'b0, 1'b0};
    tv[1] = '{3, 10'h3FF, 10'h3FF, 10'h3FF, 1'b1, 2, 21'h1FFFFF, 21'h0001FF, 1'b0, 1'b1};
    tv[2] = '{3, 10'h001, 10'h002, 10'h003, 1'b1, 2, 21'h100801, 21'h000001, 1'b0, 1'b1};
    tv[3] = '{3, 10'h155, 10'h2AA, 10'h3FF, 1'b1, 2, 21'h1AA955, 21'h0001FF, 1'b0, 1'b1};
    tv[4] = '{1, 10'h2A5, 10'h000, 10'h000, 1'b1, 1, 21'h0002A5, 21'h000000, 1'b1, 1'b0};
    tv[5] = '{2, 10'h3FF, 10'h001, 10'h000, 1'b1, 1, 21'h0007FF, 21'h000000, 1'b1, 1'b0};

    // Reset state
    clear_model();
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Vector table
    for (int i = 0; i < 6; i++) begin
      do_reset();
      wv[0] = tv[i].w0; wv[1] = tv[i].w1; wv[2] = tv[i].w2;
      dv[0] = tv[i].d0; dv[1] = tv[i].d1;
      lv[0] = tv[i].l0; lv[1] = tv[i].l1;
      for (int j = 0; j < tv[i].n_in; j++)
        cyc(1'b1, wv[j], tv[i].lst && (j == tv[i].n_in - 1), 1'b1);
      repeat (6) cyc(1'b0, '0, 1'b0, 1'b1);
      chk($sformatf("tv%0d_count", i), 32'(got_q.size()), 32'(tv[i].n_out));
      for (int j = 0; j < tv[i].n_out; j++) begin
        if (j < got_q.size()) begin
          chk($sformatf("tv%0d_data%0d", i, j), 32'(got_q[j].d), 32'(dv[j]));
          chk($sformatf("tv%0d_last%0d", i, j), 32'(got_q[j].l), 32'(lv[j]));
        end
      end
    end

    // First full word appears the cycle after the completing accept
    do_reset();
    cyc(1'b1, 10'h001, 1'b0, 1'b1);
    chk("lat_v0", 32'(s_out_valid), 32'd0);
    cyc(1'b1, 10'h002, 1'b0, 1'b1);
    chk("lat_v1", 32'(s_out_valid), 32'd0);
    cyc(1'b1, 10'h003, 1'b0, 1'b1);
    chk("lat_v2", 32'(s_out_valid), 32'd0);
    chk("lat_acc", 32'(s_acc), 32'd1);
    cyc(1'b0, '0, 1'b0, 1'b1);
    chk("lat_v3", 32'(s_out_valid), 32'd1);
    chk("lat_data", 32'(s_out_data), 32'h100801);

    // Burst of three all-ones words: in_ready stays low through both transfers
    do_reset();
    cyc(1'b1, 10'h3FF, 1'b0, 1'b1);
    cyc(1'b1, 10'h3FF, 1'b0, 1'b1);
    cyc(1'b1, 10'h3FF, 1'b1, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b1);
    chk("flush_rdy0", 32'(s_in_ready), 32'd0);
    chk("flush_last0", 32'(s_out_last), 32'd0);
    cyc(1'b0, '0, 1'b0, 1'b1);
    chk("flush_rdy1", 32'(s_in_ready), 32'd0);
    chk("flush_last1", 32'(s_out_last), 32'd1);
    cyc(1'b0, '0, 1'b0, 1'b1);
    chk("flush_rdy2", 32'(s_in_ready), 32'd1);
    chk("flush_idle", 32'(s_out_valid), 32'd0);

    // 21 words streamed with no bubble -> exactly 10 bus words
    do_reset();
    for (int j = 1; j <= 21; j++) begin
      cyc(1'b1, IW'(j), 1'b0, 1'b1);
      chk($sformatf("stream_rdy%0d", j), 32'(s_in_ready), 32'd1);
    end
    repeat (3) cyc(1'b0, '0, 1'b0, 1'b1);
    chk("stream_count", 32'(got_q.size()), 32'd10);
    chk("stream_fill", 32'(dut.fill), 32'd0);
    chk("stream_left", 32'(bits.size() + exp_q.size()), 32'd0);

    // Six-cycle out_ready stall in the middle of a stream
    do_reset();
    drops = 0;
    for (int c = 0; c < 30; c++) begin
      ordy    = !(c >= 5 && c < 11);
      exp_rdy = (pend_bits < OW) || ordy;
      cyc(1'b1, IW'($urandom), 1'b0, ordy);
      chk("stall_rdy", 32'(s_in_ready), 32'(exp_rdy));
      if (!s_in_ready) drops++;
    end
    chk("stall_saw_drop", 32'(drops > 0), 32'd1);
    k = 0;
    do begin
      cyc(1'b1, 10'h155, 1'b1, 1'b1);
      k++;
    end while (!s_acc && k < 6);
    repeat (6) cyc(1'b0, '0, 1'b0, 1'b1);
    chk("stall_drain", 32'(exp_q.size()), 32'd0);

    // Reset mid-burst discards partial bits
    do_reset();
    for (int j = 1; j <= 14; j++) cyc(1'b1, IW'(j), 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b1);
    chk("mid_fill14", 32'(dut.fill), 32'd14);
    cyc(1'b1, 10'h00F, 1'b1, 1'b0);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    #1;
    chk("mid_pre_valid", 32'(out_valid), 32'd1);
    #1;
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_last", 32'(out_last), 32'd0);
    clear_model();
    @(negedge clk);
    rst = 1'b1;
    cyc(1'b1, 10'h001, 1'b0, 1'b1);
    cyc(1'b1, 10'h002, 1'b0, 1'b1);
    cyc(1'b1, 10'h003, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b1);
    chk("mid_after_valid", 32'(s_out_valid), 32'd1);
    chk("mid_after_data", 32'(s_out_data), 32'h100801);

    // Random valid/ready with random burst ends
    do_reset();
    sent = 0;
    have = 1'b0;
    pd   = '0;
    pl   = 1'b0;
    for (int c = 0; c < 30000 && sent < 1000; c++) begin
      if (!have && ($urandom_range(0, 9) < 7)) begin
        have = 1'b1;
        pd   = IW'($urandom);
        pl   = ($urandom_range(0, 9) == 0) || (sent == 999);
      end
      ordy = ($urandom_range(0, 9) < 6);
      cyc(have, pd, pl, ordy);
      if (s_acc) begin
        sent++;
        have = 1'b0;
      end
    end
    chk("rnd_sent", 32'(sent), 32'd1000);
    for (int c = 0; c < 400 && exp_q.size() > 0; c++)
      cyc(1'b0, '0, 1'b0, 1'($urandom_range(0, 1)));
    chk("rnd_drain", 32'(exp_q.size()), 32'd0);
    chk("rnd_bits_left", 32'(bits.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/packer_tx.md
PACKER_TX -- requirements
Module: packer_tx

Interface
REQ-001 SHALL have parameter IN_W, default 10, width of one input word.
REQ-002 SHALL have parameter OUT_W, default 21, width of one packed bus word.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_data  input  IN_W  word to pack.
REQ-006 SHALL have port in_valid  input  1  in_data valid.
REQ-007 SHALL have port in_last  input  1  marks the final word of a burst; qualified by in_valid.
REQ-008 SHALL have port in_ready  output  1  word accepted when in_valid && in_ready.
REQ-009 SHALL have port out_data  output  OUT_W  packed bus word.
REQ-010 SHALL have port out_valid  output  1  out_data valid.
REQ-011 SHALL have port out_last  output  1  final, zero-padded word of a burst.
REQ-012 SHALL have port out_ready  input  1  word consumed when out_valid && out_ready.

Function
REQ-013 SHALL pack words LSB-first into a continuous bit stream: the first accepted word occupies out_data[IN_W-1:0], and a word straddling a boundary places its low bits in out_data MSBs and its remaining bits in the next word's LSBs.
REQ-014 SHALL hold an accumulator acc of IN_W+OUT_W-1 bits and a fill counter (0..IN_W+OUT_W-1 bits valid).
REQ-015 SHALL drive out_valid = (fill >= OUT_W) || (flush_pend && fill > 0) and out_data = acc[OUT_W-1:0], both derived from registers only.
REQ-016 SHALL drive in_ready = !flush_pend && (fill < OUT_W || out_ready).
REQ-017 On accept only: acc |= in_data << fill; fill += IN_W.
REQ-018 On output transfer only: acc >>= OUT_W; fill -= OUT_W, or fill = 0 when flushing.
REQ-019 On simultaneous accept and transfer: acc = (acc >> OUT_W) | (in_data << (fill-OUT_W)); fill = fill - OUT_W + IN_W in one cycle, sustaining one word per cycle with no bubble.
REQ-020 SHALL set out_data bits above fill to zero, so a flushed partial word is zero-padded.
REQ-021 Accepting a word with in_last SHALL set flush_pend; while flush_pend, in_ready=0.
REQ-022 out_last SHALL be 1 when flush_pend && fill <= OUT_W; the transfer of that word SHALL clear flush_pend and fill.
REQ-023 in_last with a total burst length that is a multiple of OUT_W SHALL mark the last full word out_last, with no extra padded word.
REQ-024 Latency: the word completing OUT_W bits SHALL produce out_valid on the following cycle.
REQ-025 With defaults, 21 input words SHALL produce exactly 10 output words, leaving fill=0.
REQ-026 out_data/out_last SHALL stay stable while out_valid && !out_ready.

Reset
REQ-027 rst low SHALL immediately clear acc, fill and flush_pend, forcing out_valid=0 and out_last=0; in_ready=1 after release.
REQ-028 Reset mid-burst SHALL discard partial bits; the first word after release SHALL start at out_data bit 0.

Structure
REQ-029 Package packer_pkg SHALL hold IN_W, OUT_W, ACC_W=IN_W+OUT_W-1 and FILL_W=$clog2(ACC_W+1), shared with the matching receiver.
REQ-030 Single module; no sub-module. The variable shifts are the only datapath.

Verification
REQ-031 Words 0x001,0x002,0x003 back-to-back with out_ready=1 -> first out_data=0x100801 one cycle after the third accept.
REQ-032 21 words 0x001..0x015 continuous, out_ready=1 -> 10 words out, in_ready never low, fill=0 at end; unpacking with the receiver reproduces the input.
REQ-033 3 words 0x3FF, in_last on third -> 0x1FFFFF (out_last=0), then 0x0001FF (out_last=1); in_ready low until the second transfer.
REQ-034 out_ready low 6 cycles during a stream -> in_ready drops once fill>=21, out_data held stable, no word lost or duplicated.
REQ-035 rst asserted with fill=14 -> out_valid=0 same cycle; next 3 words 0x001,0x002,0x003 -> 0x100801.
REQ-036 Random valid/ready toggling, 1000 words, random in_last -> scoreboard bit-exact match including padding and out_last.
